// File: rtl/fpu_issue.sv
// Multi-cycle issue/capture controller in front of the combinational FPU datapath.
// Optional sticky status flags are built when FPU_FLAGS_EN is defined.
module fpu_issue #(
   parameter int unsigned LAT_ADD  = 2,
   parameter int unsigned LAT_MUL  = 2,
   parameter int unsigned LAT_DIV  = 4,
   parameter int unsigned LAT_SQRT = 4,
   parameter int unsigned LAT_MISC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [11:0] req_op,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  logic [4:0]  req_rd,
   input  logic        flush,
   output logic [31:0] fpu_x1,
   output logic [31:0] fpu_x2,
   output logic [11:0] fpu_sel,
   input  logic [31:0] fpu_y,
   input  logic        fpu_ovf,
   input  logic        fpu_exc,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [4:0]  res_rd,
   output logic        res_ovf,
   output logic        res_exc,
   input  logic        flags_clr,
   output logic        flags_ovf,
   output logic        flags_exc
);

   localparam int unsigned OP_W   = 12;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned RD_W   = 5;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [RD_W-1:0]    rd_q;
   logic               legal_q;
   logic               accept, capture, handshake;

   // Hold count minus one; illegal (zero or multi-hot) ops take one cycle.
   function automatic logic [CNT_W-1:0] lat_m1(input logic [OP_W-1:0] op);
      logic [CNT_W-1:0] l;
      l = '0;
      if ($onehot(op)) begin
         if (op[0] || op[1])  l = CNT_W'(LAT_ADD - 1);
         else if (op[2])      l = CNT_W'(LAT_MUL - 1);
         else if (op[3])      l = CNT_W'(LAT_DIV - 1);
         else if (op[7])      l = CNT_W'(LAT_SQRT - 1);
         else                 l = CNT_W'(LAT_MISC - 1);
      end
      return l;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and transfer strobes; flush overrides everything.
   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      capture   = 1'b0;
      handshake = 1'b0;
      case (state)
         IDLE: if (req_valid) begin
            accept   = 1'b1;
            state_nx = EXEC;
         end
         EXEC: if (cnt == '0) begin
            capture  = 1'b1;
            state_nx = DONE;
         end
         DONE: if (res_ready) begin
            handshake = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush) begin
         state_nx  = IDLE;
         accept    = 1'b0;
         capture   = 1'b0;
         handshake = 1'b0;
      end
   end

   assign req_ready = (state == IDLE) && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid <= 1'b0;
         fpu_x1    <= '0;
         fpu_x2    <= '0;
         fpu_sel   <= '0;
         cnt       <= '0;
         rd_q      <= '0;
         legal_q   <= 1'b0;
         res_data  <= '0;
         res_rd    <= '0;
         res_ovf   <= 1'b0;
         res_exc   <= 1'b0;
      end else begin
         res_valid <= (state_nx == DONE);
         if (accept) begin
            fpu_x1  <= req_rs1;
            fpu_x2  <= req_rs2;
            rd_q    <= req_rd;
            legal_q <= $onehot(req_op);
            fpu_sel <= $onehot(req_op) ? req_op : '0;
            cnt     <= lat_m1(req_op);
         end else begin
            if (capture || flush) fpu_sel <= '0;
            if (state == EXEC && cnt != '0) cnt <= cnt - CNT_W'(1);
         end
         // Operands have been stable for the full multicycle window here.
         if (capture) begin
            res_data <= legal_q ? fpu_y : DATA_W'(0);
            res_rd   <= rd_q;
            res_ovf  <= legal_q && fpu_ovf;
            res_exc  <= !legal_q || fpu_exc;
         end
      end
   end

`ifdef FPU_FLAGS_EN
   // Sticky flags: a set on the handshake edge beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_ovf <= 1'b0;
         flags_exc <= 1'b0;
      end else begin
         if (handshake && res_ovf) flags_ovf <= 1'b1;
         else if (flags_clr)       flags_ovf <= 1'b0;
         if (handshake && res_exc) flags_exc <= 1'b1;
         else if (flags_clr)       flags_exc <= 1'b0;
      end
   end
`else
   logic unused_flag_inputs;
   assign unused_flag_inputs = flags_clr ^ handshake;
   assign flags_ovf = 1'b0;
   assign flags_exc = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue.sv
// Directed self-checking bench for fpu_issue with a tiny behavioural FPU model.
module tb_fpu_issue;

   logic        clk, rst;
   logic        req_valid, req_ready;
   logic [11:0] req_op;
   logic [31:0] req_rs1, req_rs2;
   logic [4:0]  req_rd;
   logic        flush;
   logic [31:0] fpu_x1, fpu_x2, fpu_y;
   logic [11:0] fpu_sel;
   logic        fpu_ovf, fpu_exc;
   logic        res_valid, res_ready;
   logic [31:0] res_data;
   logic [4:0]  res_rd;
   logic        res_ovf, res_exc;
   logic        flags_clr, flags_ovf, flags_exc;
   logic        ovf_drv, exc_drv;

   int n_cmp = 0;
   int n_err = 0;

`ifdef FPU_FLAGS_EN
   localparam logic FLAGS_ON = 1'b1;
`else
   localparam logic FLAGS_ON = 1'b0;
`endif

   fpu_issue dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
      .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_sel(fpu_sel),
      .fpu_y(fpu_y), .fpu_ovf(fpu_ovf), .fpu_exc(fpu_exc),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_rd(res_rd), .res_ovf(res_ovf), .res_exc(res_exc),
      .flags_clr(flags_clr), .flags_ovf(flags_ovf), .flags_exc(flags_exc)
   );

   // FPU model: 1.0+2.0 gives 3.0, otherwise an xor signature of operands and select.
   assign fpu_y = (fpu_sel == 12'h001 && fpu_x1 == 32'h3F80_0000 && fpu_x2 == 32'h4000_0000)
                  ? 32'h4040_0000 : (fpu_x1 ^ fpu_x2 ^ {20'd0, fpu_sel});
   assign fpu_ovf = ovf_drv && (fpu_sel != '0);
   assign fpu_exc = exc_drv && (fpu_sel != '0);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_res();
      for (int i = 0; i < 20 && !res_valid; i++) step();
      chk("res_timeout", 32'(res_valid), 32'd1);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
      flush = 1'b0; res_ready = 1'b0; flags_clr = 1'b0; ovf_drv = 1'b0; exc_drv = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_fpu_sel",   32'(fpu_sel),   32'd0);
      chk("rst_fpu_x1",    fpu_x1,         32'd0);
      chk("rst_res_data",  res_data,       32'd0);
      chk("rst_flags",     32'({flags_ovf, flags_exc}), 32'd0);

      // fadds: 2-cycle hold, result at T+2
      issue(12'h001, 32'h3F80_0000, 32'h4000_0000, 5'd5);
      chk("add_sel_t0",   32'(fpu_sel),   32'h001);
      chk("add_x1",       fpu_x1,         32'h3F80_0000);
      chk("add_ready_t0", 32'(req_ready), 32'd0);
      chk("add_valid_t0", 32'(res_valid), 32'd0);
      step();
      chk("add_sel_t1",   32'(fpu_sel),   32'h001);
      chk("add_valid_t1", 32'(res_valid), 32'd0);
      step();
      chk("add_valid_t2", 32'(res_valid), 32'd1);
      chk("add_sel_t2",   32'(fpu_sel),   32'd0);
      chk("add_data",     res_data,       32'h4040_0000);
      chk("add_rd",       32'(res_rd),    32'd5);
      chk("add_exc",      32'(res_exc),   32'd0);
      res_ready = 1'b1;
      step();
      chk("add_idle_valid", 32'(res_valid), 32'd0);
      chk("add_idle_ready", 32'(req_ready), 32'd1);

      // fdivs with writeback stall: 0x40800000 ^ 0x40000000 ^ 0x008
      res_ready = 1'b0;
      issue(12'h008, 32'h4080_0000, 32'h4000_0000, 5'd9);
      repeat (3) step();
      chk("div_valid_t3", 32'(res_valid), 32'd0);
      chk("div_sel_t3",   32'(fpu_sel),   32'h008);
      step();
      chk("div_valid_t4", 32'(res_valid), 32'd1);
      chk("div_data",     res_data,       32'h0080_0008);
      for (int i = 0; i < 5; i++) step();
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_data",  res_data,       32'h0080_0008);
      chk("stall_rd",    32'(res_rd),    32'd9);
      chk("stall_ready", 32'(req_ready), 32'd0);
      res_ready = 1'b1;
      step();
      chk("stall_release_ready", 32'(req_ready), 32'd1);
      chk("stall_release_valid", 32'(res_valid), 32'd0);

      // illegal multi-hot op
      res_ready = 1'b0; ovf_drv = 1'b1;
      issue(12'h003, 32'h1234_5678, 32'h0000_FFFF, 5'd3);
      chk("ill_sel",   32'(fpu_sel),   32'd0);
      chk("ill_ready", 32'(req_ready), 32'd0);
      step();
      chk("ill_valid", 32'(res_valid), 32'd1);
      chk("ill_data",  res_data,       32'd0);
      chk("ill_exc",   32'(res_exc),   32'd1);
      chk("ill_ovf",   32'(res_ovf),   32'd0);
      chk("ill_rd",    32'(res_rd),    32'd3);
      res_ready = 1'b1; ovf_drv = 1'b0;
      step();

      // flush mid-fsqrts
      res_ready = 1'b0;
      issue(12'h080, 32'h4110_0000, 32'h0, 5'd7);
      chk("sqrt_sel", 32'(fpu_sel), 32'h080);
      flush = 1'b1;
      step();
      chk("flush_valid", 32'(res_valid), 32'd0);
      chk("flush_sel",   32'(fpu_sel),   32'd0);
      req_valid = 1'b1; req_op = 12'h004; req_rs1 = 32'hAAAA_0000; req_rd = 5'd1;
      #1;
      chk("flush_ready", 32'(req_ready), 32'd0);
      step();
      chk("flush_not_taken_sel", 32'(fpu_sel), 32'd0);
      chk("flush_not_taken_x1",  fpu_x1,       32'h4110_0000);
      flush = 1'b0; req_valid = 1'b0;
      #1;
      chk("flush_idle_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 6; i++) step();
      chk("flush_no_result", 32'(res_valid), 32'd0);

      // sticky flags
      res_ready = 1'b1; ovf_drv = 1'b1;
      issue(12'h004, 32'h2, 32'h3, 5'd2);
      wait_res();
      chk("mul_ovf", 32'(res_ovf), 32'd1);
      ovf_drv = 1'b0;
      step();
      chk("flag_set", 32'(flags_ovf), 32'(FLAGS_ON));
      issue(12'h010, 32'h5, 32'h5, 5'd4);
      wait_res();
      chk("feq_data", res_data, 32'h0000_0010);
      step();
      chk("flag_persist", 32'(flags_ovf), 32'(FLAGS_ON));
      chk("flag_exc_clean", 32'(flags_exc), 32'd0);
      flags_clr = 1'b1;
      step();
      flags_clr = 1'b0;
      chk("flag_cleared", 32'(flags_ovf), 32'd0);
      ovf_drv = 1'b1;
      issue(12'h004, 32'h6, 32'h1, 5'd6);
      wait_res();
      flags_clr = 1'b1;
      step();
      flags_clr = 1'b0; ovf_drv = 1'b0;
      chk("flag_set_beats_clr", 32'(flags_ovf), 32'(FLAGS_ON));

      // async reset between edges mid-EXEC
      res_ready = 1'b0;
      issue(12'h008, 32'h7777_0000, 32'h0000_1111, 5'd8);
      step();
      #3 rst = 1'b1;
      #1;
      chk("arst_sel",   32'(fpu_sel),   32'd0);
      chk("arst_x1",    fpu_x1,         32'd0);
      chk("arst_data",  res_data,       32'd0);
      chk("arst_ready", 32'(req_ready), 32'd1);
      chk("arst_flags", 32'(flags_ovf), 32'd0);
      #1 rst = 1'b0;
      step();
      res_ready = 1'b1;
      issue(12'h001, 32'h3F80_0000, 32'h4000_0000, 5'd11);
      step();
      chk("post_rst_valid_t1", 32'(res_valid), 32'd0);
      step();
      chk("post_rst_valid_t2", 32'(res_valid), 32'd1);
      chk("post_rst_data",     res_data,       32'h4040_0000);
      chk("post_rst_rd",       32'(res_rd),    32'd11);
      step();
      chk("post_rst_idle", 32'(req_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
